// File: rtl/datapath_sequencer.sv
// -----------------------------------------------------------------------------
// datapath_sequencer
//
// Multi-cycle controller that walks the register-file/ALU datapath through one
// instruction at a time (addi, add, sub, bne). An instruction is taken over a
// valid/ready handshake and then goes IDLE -> DECODE -> EXEC -> RETIRE.
// Illegal encodings skip EXEC and retire with an illegal pulse.
//
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   instr_valid   instruction presented by the source
//   instr         32-bit RV32 instruction word
//   instr_ready   sequencer is idle and will capture instr on this edge
//   EQ            equal flag from the datapath ALU, sampled at the end of EXEC
//   AD1/AD2/AD3   register-file read (rs1, rs2) and write (rd) addresses
//   WE3           register-file write enable (EXEC only)
//   ALUSrc        ALU operand b select: 0 = RD2, 1 = ImmOp
//   ALUCtrl       ALU operation: 0 = add, 1 = sub
//   ImmOp         sign-extended immediate
//   pc            program counter
//   busy          high whenever the sequencer is not idle
//   done          one-cycle pulse when a legal instruction retires
//   illegal       one-cycle pulse when an illegal instruction retires
// -----------------------------------------------------------------------------
module datapath_sequencer #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  input  logic        EQ,
  output logic [4:0]  AD1,
  output logic [4:0]  AD2,
  output logic [4:0]  AD3,
  output logic        WE3,
  output logic        ALUSrc,
  output logic        ALUCtrl,
  output logic [31:0] ImmOp,
  output logic [31:0] pc,
  output logic        busy,
  output logic        done,
  output logic        illegal
);

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    EXEC,
    RETIRE
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] ir;
  logic [31:0] pc_q;
  logic        illegal_q;

  // Instruction fields and decode, all taken from the held instruction register
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        is_addi;
  logic        is_add;
  logic        is_sub;
  logic        is_bne;
  logic        is_legal;
  logic [31:0] imm_i;
  logic [31:0] imm_b;
  logic [31:0] pc_next;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign funct7 = ir[31:25];

  assign is_addi  = (opcode == 7'b0010011) && (funct3 == 3'b000);
  assign is_add   = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0000000);
  assign is_sub   = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0100000);
  assign is_bne   = (opcode == 7'b1100011) && (funct3 == 3'b001);
  assign is_legal = is_addi || is_add || is_sub || is_bne;

  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};

  // A taken bne (registers differ) jumps by the branch offset; everything
  // else that reaches EXEC simply advances to the next word.
  assign pc_next = (is_bne && !EQ) ? (pc_q + imm_b) : (pc_q + 32'd4);

  assign pc = pc_q;

  // State, instruction register, program counter and retire-kind flag.
  // IR is only loaded on an accepted handshake; pc only moves on the edge
  // that ends EXEC, so an illegal instruction or a reset before that edge
  // leaves it untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ir        <= 32'h0;
      pc_q      <= PC_RESET;
      illegal_q <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && instr_valid) begin
        ir <= instr;
      end
      if (state == DECODE) begin
        illegal_q <= !is_legal;
      end
      if (state == EXEC) begin
        pc_q <= pc_next;
      end
    end
  end

  // Next-state logic and all combinational outputs. Datapath controls are
  // only driven in DECODE and EXEC for legal instructions; IDLE and RETIRE
  // present an all-zero control word. instr_ready is also masked by rst so
  // that every output reads zero while reset is held.
  always_comb begin
    state_next  = state;
    instr_ready = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    AD1         = 5'd0;
    AD2         = 5'd0;
    AD3         = 5'd0;
    WE3         = 1'b0;
    ALUSrc      = 1'b0;
    ALUCtrl     = 1'b0;
    ImmOp       = 32'h0;

    if (state == DECODE || state == EXEC) begin
      if (is_legal) begin
        AD1     = rs1;
        AD2     = is_addi ? 5'd0 : rs2;
        AD3     = is_bne ? 5'd0 : rd;
        ALUSrc  = is_addi;
        ALUCtrl = is_sub || is_bne;
        if (is_addi) begin
          ImmOp = imm_i;
        end else if (is_bne) begin
          ImmOp = imm_b;
        end
      end
    end

    case (state)
      IDLE: begin
        instr_ready = !rst;
        if (instr_valid && !rst) begin
          state_next = DECODE;
        end
      end
      DECODE: begin
        busy       = 1'b1;
        state_next = is_legal ? EXEC : RETIRE;
      end
      EXEC: begin
        busy       = 1'b1;
        WE3        = !is_bne && (rd != 5'd0);
        state_next = RETIRE;
      end
      RETIRE: begin
        busy       = 1'b1;
        done       = !illegal_q;
        illegal    = illegal_q;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: doc/datapath_sequencer.md
# datapath_sequencer

Multi-cycle controller that sequences the register-file/ALU datapath block one instruction at a time. It accepts a 32-bit instruction over a valid/ready handshake and decodes the reduced ISA: addi, add, sub and bne. It drives the datapath's read/write addresses, write enable, operand-mux select, ALU control and immediate, and keeps the program counter. It sits between the instruction source and the datapath and replaces the single-cycle control unit.

## Interface
- PC_RESET, 32'h0000_0000, PC value loaded on reset
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- instr_valid  in  1  instruction presented
- instr  in  32  RV32 instruction word
- instr_ready  out  1  sequencer can accept an instruction
- EQ  in  1  equal flag from datapath ALU
- AD1  out  5  read address 1 (rs1)
- AD2  out  5  read address 2 (rs2)
- AD3  out  5  write address (rd)
- WE3  out  1  register write enable
- ALUSrc  out  1  0 = RD2, 1 = ImmOp to ALU operand b
- ALUCtrl  out  1  0 = add, 1 = sub
- ImmOp  out  32  sign-extended immediate
- pc  out  32  program counter
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse on legal instruction retire
- illegal  out  1  one-cycle pulse on illegal instruction retire

## Operation
- States: IDLE, DECODE, EXEC, RETIRE. The state, the 32-bit IR, pc, and the retire-kind flag are registers. All datapath controls are combinational from state and IR.
- IDLE: instr_ready=1. All datapath outputs are 0. When instr_valid && instr_ready, IR <= instr and the next state is DECODE. instr_valid is ignored in every other state.
- Decode of IR:
  - opcode 0010011, funct3 000 -> addi
  - opcode 0110011, funct3 000, funct7 0000000 -> add
  - opcode 0110011, funct3 000, funct7 0100000 -> sub
  - opcode 1100011, funct3 001 -> bne
  - Every other encoding is illegal.
- Immediates:
  - I-type = sign-extend IR[31:20].
  - B-type = {{19{IR[31]}}, IR[31], IR[7], IR[30:25], IR[11:8], 1'b0}.
  - ImmOp = 0 for add, sub and illegal.
- DECODE and EXEC both drive the following for legal instructions:
  - AD1 = IR[19:15].
  - AD2 = IR[24:20] for add, sub and bne; 0 for addi.
  - AD3 = IR[11:7] for addi, add and sub; 0 for bne.
  - ALUSrc = 1 only for addi.
  - ALUCtrl = 1 for sub and bne.
  - ImmOp per the immediate rules above.
- DECODE -> EXEC for legal instructions. DECODE -> RETIRE for illegal instructions, with the illegal flag set.
- EXEC:
  - addi/add/sub: WE3=1 for exactly this cycle, so the write lands on the edge that ends EXEC. WE3 stays 0 if AD3==0.
  - bne: WE3=0. EQ is sampled on the edge that ends EXEC. pc <= pc + ImmOp if EQ==0, else pc + 4.
  - Non-branch: pc <= pc + 4 on the same edge.
  - EXEC -> RETIRE.
- RETIRE: done=1 (legal) or illegal=1 (illegal), never both. Datapath outputs are 0. RETIRE -> IDLE.
- Illegal instruction: pc unchanged and WE3 never asserted.
- pc arithmetic is modulo 2^32; wrap-around is silent.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE, IR=0, pc=PC_RESET.
  - All outputs 0 while rst is high, including instr_ready.
  - instr_ready=1 from the first cycle after rst deasserts.
- Handshake accepted at edge N. DECODE occupies cycle N+1, EXEC N+2, RETIRE N+3. instr_ready is high again in cycle N+4.
- Throughput: one instruction per 4 cycles.
- pc holds its new value from RETIRE onward; pc is stable in IDLE.
- WE3 is high for at most one cycle per instruction and only in EXEC.
- rst asserted mid-instruction, including during EXEC:
  - WE3 drops combinationally and no write or pc update occurs.
  - No done or illegal pulse is issued.
  - The instruction is discarded.
- instr_valid high with instr_ready low: no capture. The source must hold the instruction until it is accepted.

## Test plan
- Reset: assert rst mid-stream, then release -> pc=PC_RESET, busy=0, instr_ready=1, WE3=0, done=0.
- addi x10,x0,5 (0x00500513) at pc=0:
  - DECODE: AD1=0, AD3=10, ALUSrc=1, ALUCtrl=0, ImmOp=5.
  - EXEC: WE3=1 for one cycle.
  - RETIRE: done pulse; pc=4.
- sub x5,x6,x7 (0x407302B3) -> AD1=6, AD2=7, AD3=5, ALUSrc=0, ALUCtrl=1, ImmOp=0, WE3 one cycle, pc+=4. addi x0,x0,1 (0x00100013) -> WE3 never asserts, done pulses.
- bne x10,x0,-4 (0xFE051EE3) at pc=8:
  - ImmOp=0xFFFFFFFC, ALUCtrl=1, WE3 never.
  - EQ=0 in EXEC -> pc=4.
  - Repeat with EQ=1 -> pc=12.
- Illegal 0x00000000 -> illegal pulse in RETIRE, no done, WE3 never, pc unchanged; ready returns 3 cycles after accept.
- Back-to-back: instr_valid held high with 3 instructions -> each accepted exactly once, 4 cycles apart. rst asserted during EXEC of the second -> WE3 falls immediately, no pulse, pc=PC_RESET.
